hex_stream_loader: RTL

- Sequences the ASCII-to-hex digit conversion for the boot/program loader.
- Consumes a byte stream of ASCII hex text from the UART receiver and assembles 4*WORD_DIGITS-bit words, MSB digit first.
- Writes each word to program memory at consecutive addresses through a valid/ready write port.
- Detects malformed input, overruns and address-space exhaustion, and terminates cleanly on '$'.

---
 rtl/hex_stream_loader.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/hex_stream_loader.sv
// ASCII hex text loader: assembles MSB-first hex digits from a UART byte stream
// into words and writes them to program memory over a valid/ready port.

module ascii_to_hex_converter (
  input  logic [7:0] ascii,
  output logic [3:0] hex,
  output logic       is_hex
);
  always_comb begin
    hex    = '0;
    is_hex = 1'b0;
    if (ascii >= 8'h30 && ascii <= 8'h39) begin
      hex    = ascii[3:0];
      is_hex = 1'b1;
    end else if ((ascii >= 8'h41 && ascii <= 8'h46) ||
                 (ascii >= 8'h61 && ascii <= 8'h66)) begin
      // 'A'/'a' have low nibble 1, so +9 yields 10..15
      hex    = ascii[3:0] + 4'd9;
      is_hex = 1'b1;
    end
  end
endmodule

module hex_stream_loader #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WORD_DIGITS = 8,
  parameter int BASE_ADDR   = 0,
  parameter int ADDR_STEP   = 1
) (
  input  logic                    Clk,
  input  logic                    Nrst,
  input  logic                    Enable,
  input  logic [7:0]              Rx_data,
  input  logic                    Rx_valid,
  output logic [ADDR_WIDTH-1:0]   Mem_addr,
  output logic [4*WORD_DIGITS-1:0] Mem_wdata,
  output logic                    Mem_we,
  input  logic                    Mem_ready,
  output logic                    Busy,
  output logic                    Done,
  output logic                    Error,
  output logic [2:0]              Error_code,
  output logic [ADDR_WIDTH:0]     Word_count
);
  localparam int W  = 4 * WORD_DIGITS;
  localparam int CW = $clog2(WORD_DIGITS + 1);

  typedef enum logic [2:0] {IDLE, COLLECT, WRITE, DONE, ERROR} state_t;
  typedef enum logic [2:0] {E_NONE, E_BADCHAR, E_PARTIAL, E_OVERRUN, E_FULL} err_t;

  state_t                state_q, state_d;
  err_t                  err_q, err_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [W-1:0]          wdata_q, wdata_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH:0]   wc_q, wc_d;
  logic [CW-1:0]         dcnt_q, dcnt_d;
  logic                  full_q, full_d;

  logic [3:0]            digit;
  logic                  is_hex;
  logic                  is_space, is_term;
  logic [ADDR_WIDTH:0]   addr_sum;

  ascii_to_hex_converter u_conv (
    .ascii  (Rx_data),
    .hex    (digit),
    .is_hex (is_hex)
  );

  assign is_space = (Rx_data == 8'h20) || (Rx_data == 8'h09) ||
                    (Rx_data == 8'h0A) || (Rx_data == 8'h0D);
  assign is_term  = (Rx_data == 8'h24);
  // Carry out of the widened sum marks address-space exhaustion
  assign addr_sum = {1'b0, addr_q} + (ADDR_WIDTH+1)'(ADDR_STEP);

  always_ff @(posedge Clk or negedge Nrst) begin
    if (!Nrst) begin
      state_q <= IDLE;
      err_q   <= E_NONE;
      addr_q  <= ADDR_WIDTH'(BASE_ADDR);
      wdata_q <= '0;
      we_q    <= 1'b0;
      wc_q    <= '0;
      dcnt_q  <= '0;
      full_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      wc_q    <= wc_d;
      dcnt_q  <= dcnt_d;
      full_q  <= full_d;
    end
  end

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    wc_d    = wc_q;
    dcnt_d  = dcnt_q;
    full_d  = full_q;

    case (state_q)
      IDLE: begin
        err_d = E_NONE;
        if (Enable) begin
          state_d = COLLECT;
          addr_d  = ADDR_WIDTH'(BASE_ADDR);
          wc_d    = '0;
          dcnt_d  = '0;
          full_d  = 1'b0;
          wdata_d = '0;
          we_d    = 1'b0;
        end
      end

      COLLECT: begin
        if (!Enable) begin
          state_d = IDLE;
          we_d    = 1'b0;
        end else if (Rx_valid) begin
          if (is_hex) begin
            if (full_q) begin
              state_d = ERROR;
              err_d   = E_FULL;
            end else begin
              wdata_d = (wdata_q << 4) | W'(digit);
              dcnt_d  = dcnt_q + 1'b1;
              if (dcnt_q == CW'(WORD_DIGITS - 1)) begin
                state_d = WRITE;
                we_d    = 1'b1;
              end
            end
          end else if (is_space) begin
            if (dcnt_q != '0) begin
              state_d = ERROR;
              err_d   = E_PARTIAL;
            end
          end else if (is_term) begin
            state_d = (dcnt_q == '0) ? DONE : ERROR;
            if (dcnt_q != '0) err_d = E_PARTIAL;
          end else begin
            state_d = ERROR;
            err_d   = E_BADCHAR;
          end
        end
      end

      WRITE: begin
        // A write accepted in the same cycle as abort/overrun still counts
        if (Mem_ready) begin
          we_d   = 1'b0;
          addr_d = addr_sum[ADDR_WIDTH-1:0];
          wc_d   = wc_q + 1'b1;
          dcnt_d = '0;
          if (addr_sum[ADDR_WIDTH]) full_d = 1'b1;
          state_d = COLLECT;
        end
        if (!Enable) begin
          state_d = IDLE;
          we_d    = 1'b0;
        end else if (Rx_valid) begin
          state_d = ERROR;
          err_d   = E_OVERRUN;
          we_d    = 1'b0;
        end
      end

      DONE: begin
        if (!Enable) state_d = IDLE;
      end

      ERROR: begin
        if (!Enable) begin
          state_d = IDLE;
          err_d   = E_NONE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign Mem_addr   = addr_q;
  assign Mem_wdata  = wdata_q;
  assign Mem_we     = we_q;
  assign Word_count = wc_q;
  assign Error_code = err_q;
  assign Busy       = (state_q == COLLECT) || (state_q == WRITE);
  assign Done       = (state_q == DONE);
  assign Error      = (state_q == ERROR);
endmodule
